// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Program-memory access sequencer (setup / timed access / recovery)
//
// Purpose:
//   Takes one read or write command at a time and drives the program memory
//   strobes with a one-cycle setup phase, a counted access window
//   (WR_WAIT or RD_WAIT cycles with mem_sel high) and a response phase, so
//   the memory's internal access time is always covered.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_we/cmd_addr/cmd_wdata        command payload
//   rsp_valid/rsp_ready              response handshake
//   rsp_we/rsp_rdata                 response payload
//   busy                             controller not in IDLE
//   mem_sel/mem_we/mem_addr/mem_wdata/mem_rdata  program memory interface

module mem_access_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int WR_WAIT = 10,
    parameter int RD_WAIT = 9,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter value on the final cycle of the access window.
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);

    localparam bit PARAMS_OK = (WR_WAIT >= 1) && (WR_WAIT < (1 << CNT_W)) &&
                               (RD_WAIT >= 1) && (RD_WAIT < (1 << CNT_W));

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_sel_q, mem_sel_d;
    logic              mem_we_q, mem_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              last_beat;

    assign last_beat = (cnt_q == (we_q ? WR_LAST : RD_LAST));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_sel_d   = mem_sel_q;
        mem_we_d    = mem_we_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    // mem_we is set a cycle ahead of mem_sel so it is already
                    // stable during SETUP.
                    mem_we_d = cmd_we;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d     = '0;
                mem_sel_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (last_beat) begin
                    mem_sel_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    cnt_d       = '0;
                    if (!we_q) begin
                        rsp_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_we_d    = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_sel_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_sel_q   <= mem_sel_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // A zero or overflowing wait count would break the access window.
    always @(posedge clk) begin
        assert (PARAMS_OK)
        else $error("mem_access_ctrl: WR_WAIT/RD_WAIT out of range for CNT_W");
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_sel   = mem_sel_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - Scoreboard bench for mem_access_ctrl
//
// Purpose:
//   Drives directed read/write sequences, models the program memory and the
//   expected responses, and checks strobe timing, payload stability and
//   response contents.
//
// Ports: none (top-level bench).

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_we;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        mem_sel;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W (8),
        .DATA_W (16),
        .WR_WAIT(10),
        .RD_WAIT(9),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_we   (rsp_we),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .mem_sel  (mem_sel),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Program memory stand-in.
    logic [15:0] mem_array [256];
    assign mem_rdata = mem_array[mem_addr];
    always @(posedge clk) begin
        if (mem_sel && mem_we) mem_array[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [256];
    logic [15:0] last_rd = 16'h0000;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          sel_run = 0;
    int          last_len = 0;
    int          gap = 0;
    bit          had_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: strobe timing, payload stability, scoreboard push/pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            sel_run = 0;
            gap     = 0;
            had_acc = 0;
            last_rd = 16'h0000;
        end else begin
            if (mem_sel) begin
                if (sel_run == 0 && had_acc) check("sel_gap_ge2", gap >= 2, 1);
                sel_run++;
                if (exp_q.size() == 0) begin
                    check("sel_without_cmd", 0, 1);
                end else begin
                    check("acc_mem_we", mem_we, exp_q[0].we);
                    check("acc_mem_addr", mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) check("acc_mem_wdata", mem_wdata, exp_q[0].wdata);
                end
            end else begin
                if (sel_run != 0) begin
                    last_len = sel_run;
                    had_acc  = 1;
                    gap      = 0;
                end
                sel_run = 0;
                gap++;
            end

            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_without_cmd", 0, 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_we", rsp_we, e.we);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("sel_len", last_len, e.len);
                    check("done_mem_sel", mem_sel, 0);
                    check("done_mem_we", mem_we, 0);
                end
            end

            if (cmd_valid && cmd_ready) begin
                exp_t e;
                e.we    = cmd_we;
                e.addr  = cmd_addr;
                e.wdata = cmd_wdata;
                e.len   = cmd_we ? 10 : 9;
                if (cmd_we) begin
                    ref_mem[cmd_addr] = cmd_wdata;
                    e.rdata = last_rd;
                end else begin
                    e.rdata = ref_mem[cmd_addr];
                    last_rd = e.rdata;
                end
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic we, input logic [7:0] a, input logic [15:0] d, input bit hold);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        check("accept_in_time", ok, 1);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (!busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("drain_in_time", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_sel", mem_sel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_mem_we", mem_we, 0);
        check("post_rst_rsp_we", rsp_we, 0);
        check("post_rst_rsp_rdata", rsp_rdata, 16'h0000);
        check("post_rst_mem_addr", mem_addr, 8'h00);
        check("post_rst_mem_wdata", mem_wdata, 16'h0000);

        // Write then read.
        rsp_ready = 1'b1;
        send(1'b1, 8'h3C, 16'hA5F0, 0);
        drain();
        send(1'b0, 8'h3C, 16'h0000, 0);
        drain();
        check("rd_3c_rdata", rsp_rdata, 16'hA5F0);

        // Back-to-back with cmd_valid and rsp_ready held high.
        send(1'b1, 8'h00, 16'h1111, 1);
        send(1'b1, 8'h01, 16'h2222, 1);
        send(1'b0, 8'h00, 16'h0000, 1);
        send(1'b0, 8'h01, 16'h0000, 0);
        drain();

        // Response backpressure.
        send(1'b1, 8'h10, 16'hBEEF, 0);
        drain();
        rsp_ready = 1'b0;
        send(1'b0, 8'h10, 16'h0000, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        check("bp_rsp_valid_seen", ok, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 16'hBEEF);
            check("bp_mem_sel", mem_sel, 0);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_not_taken_on_hs", cmd_ready, 0);
        @(negedge clk);
        check("bp_taken_next_cycle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();

        // Address/data stability during the access window.
        send(1'b1, 8'h33, 16'h5A5A, 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cmd_addr  = 8'($urandom);
            cmd_wdata = 16'($urandom);
            if (!busy) break;
        end
        drain();
        send(1'b0, 8'h33, 16'h0000, 0);
        drain();

        // Boundary values; writes must leave rsp_rdata at the last read value.
        send(1'b1, 8'hFF, 16'hFFFF, 0);
        drain();
        send(1'b1, 8'h00, 16'h0000, 0);
        drain();
        check("rdata_held_after_writes", rsp_rdata, 16'h5A5A);
        send(1'b0, 8'hFF, 16'h0000, 0);
        drain();
        send(1'b0, 8'h00, 16'h0000, 0);
        drain();

        // Reset in the middle of an access.
        send(1'b1, 8'h55, 16'h7777, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_sel && sel_run >= 3) begin
                ok = 1;
                break;
            end
        end
        check("mid_access_reached", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_sel", mem_sel, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_midrst_cmd_ready", cmd_ready, 1);
        check("after_midrst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
